clock_set_ctrl: RTL and testbench

Time-setting controller for the 7-segment wall clock. It debounces three pushbuttons and runs a RUN / SET_HR / SET_MIN state machine. In RUN it lets the timekeeper count; in the SET states it freezes the timekeeper, edits a shadow hours/minutes pair and commits it with a one-cycle load. It also supplies the digit values and a blink mask to the display scanner, so the digit being edited flashes on the anodes.

---
 rtl/clock_set_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Wall-clock time-setting controller: debounced buttons, RUN/SET_HR/SET_MIN
// FSM, shadow edit registers with one-cycle load, display mux, blink mask.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   btn_mode/inc/dec    raw asynchronous pushbuttons
//   cur_hours/minutes   live timekeeper value
//   run_en, load        timekeeper count enable and commit strobe
//   load_hours/minutes  committed value, held between loads
//   disp_hours/minutes  value shown by the display scanner
//   blink_mask          1 = blank that anode ([3:2] hours, [1:0] minutes)

module btn_debounce #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          level_dly_q;
  logic          press_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      // Level flips on the CYCLES-th consecutive mismatching sample.
      if (sync_q[1] != level_q) begin
        if (cnt_q == CW'(CYCLES - 1)) begin
          level_q <= ~level_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign press_o = press_q;
endmodule

module clock_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned BLINK_HALF      = 25000000,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic       run_en,
  output logic       load,
  output logic [4:0] load_hours,
  output logic [5:0] load_minutes,
  output logic [4:0] disp_hours,
  output logic [5:0] disp_minutes,
  output logic [3:0] blink_mask
);
  localparam int BW =
    (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN, SET_HR, SET_MIN
  } state_e;

  logic p_mode, p_inc, p_dec;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .reset(reset), .btn_i(btn_mode), .press_o(p_mode)
  );
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk(clk), .reset(reset), .btn_i(btn_inc), .press_o(p_inc)
  );
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .clk(clk), .reset(reset), .btn_i(btn_dec), .press_o(p_dec)
  );

  state_e        state_q, state_d;
  logic [4:0]    edit_h_q, edit_h_d;
  logic [5:0]    edit_m_q, edit_m_d;
  logic          load_q, load_d;
  logic [4:0]    ld_h_q, ld_h_d;
  logic [5:0]    ld_m_q, ld_m_d;
  logic          run_en_q, run_en_d;
  logic [3:0]    mask_q, mask_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [IW-1:0] idle_q, idle_d;

  logic in_set;
  logic any_press;
  logic inc_ev;
  logic dec_ev;
  logic timeout;

  always_comb begin
    state_d  = state_q;
    edit_h_d = edit_h_q;
    edit_m_d = edit_m_q;
    load_d   = 1'b0;
    ld_h_d   = ld_h_q;
    ld_m_d   = ld_m_q;
    blink_d  = blink_q;
    phase_d  = phase_q;
    idle_d   = idle_q;

    in_set    = (state_q != RUN);
    any_press = p_mode | p_inc | p_dec;
    // Mode wins; inc together with dec cancels out.
    inc_ev    = p_inc & ~p_dec & ~p_mode;
    dec_ev    = p_dec & ~p_inc & ~p_mode;

    if (!in_set || any_press) begin
      idle_d = '0;
    end else if (idle_q != IW'(TIMEOUT_CYCLES)) begin
      idle_d = idle_q + 1'b1;
    end
    timeout = in_set && !any_press &&
              (idle_d == IW'(TIMEOUT_CYCLES));

    unique case (state_q)
      RUN: begin
        if (p_mode) begin
          edit_h_d = cur_hours;
          edit_m_d = cur_minutes;
          state_d  = SET_HR;
        end
      end
      SET_HR: begin
        unique case (1'b1)
          p_mode:  state_d = SET_MIN;
          inc_ev:  edit_h_d = (edit_h_q == 5'd23) ?
                              5'd0 : edit_h_q + 5'd1;
          dec_ev:  edit_h_d = (edit_h_q == 5'd0) ?
                              5'd23 : edit_h_q - 5'd1;
          timeout: state_d = RUN;
          default: ;
        endcase
      end
      SET_MIN: begin
        unique case (1'b1)
          p_mode: begin
            load_d  = 1'b1;
            ld_h_d  = edit_h_q;
            ld_m_d  = edit_m_q;
            state_d = RUN;
          end
          inc_ev:  edit_m_d = (edit_m_q == 6'd59) ?
                              6'd0 : edit_m_q + 6'd1;
          dec_ev:  edit_m_d = (edit_m_q == 6'd0) ?
                              6'd59 : edit_m_q - 6'd1;
          timeout: state_d = RUN;
          default: ;
        endcase
      end
      default: state_d = RUN;
    endcase

    // Phase restarts visible on any state change or inc/dec press.
    if (state_d == RUN || state_d != state_q ||
        p_inc || p_dec) begin
      blink_d = '0;
      phase_d = 1'b0;
    end else if (blink_q == BW'(BLINK_HALF - 1)) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end else begin
      blink_d = blink_q + 1'b1;
    end

    run_en_d = (state_d == RUN);
    mask_d   = 4'b0000;
    if (phase_d) begin
      if (state_d == SET_HR)  mask_d = 4'b1100;
      if (state_d == SET_MIN) mask_d = 4'b0011;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      edit_h_q <= '0;
      edit_m_q <= '0;
      load_q   <= 1'b0;
      ld_h_q   <= '0;
      ld_m_q   <= '0;
      run_en_q <= 1'b1;
      mask_q   <= '0;
      blink_q  <= '0;
      phase_q  <= 1'b0;
      idle_q   <= '0;
    end else begin
      state_q  <= state_d;
      edit_h_q <= edit_h_d;
      edit_m_q <= edit_m_d;
      load_q   <= load_d;
      ld_h_q   <= ld_h_d;
      ld_m_q   <= ld_m_d;
      run_en_q <= run_en_d;
      mask_q   <= mask_d;
      blink_q  <= blink_d;
      phase_q  <= phase_d;
      idle_q   <= idle_d;
    end
  end

  assign run_en       = run_en_q;
  assign load         = load_q;
  assign load_hours   = ld_h_q;
  assign load_minutes = ld_m_q;
  assign blink_mask   = mask_q;
  assign disp_hours   =
    (state_q == RUN) ? cur_hours : edit_h_q;
  assign disp_minutes =
    (state_q == RUN) ? cur_minutes : edit_m_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed button sequences, load scoreboard
// checked by an independent monitor, plus direct output checks.

module tb_clock_set_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_inc, btn_dec;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic       run_en, load;
  logic [4:0] load_hours, disp_hours;
  logic [5:0] load_minutes, disp_minutes;
  logic [3:0] blink_mask;

  int total = 0;
  int bad = 0;
  int loads_seen = 0;

  typedef struct {
    logic [4:0] h;
    logic [5:0] m;
  } ld_t;
  ld_t exp_q[$];

  clock_set_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .BLINK_HALF(8),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .btn_dec(btn_dec),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes),
    .run_en(run_en), .load(load),
    .load_hours(load_hours), .load_minutes(load_minutes),
    .disp_hours(disp_hours), .disp_minutes(disp_minutes),
    .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Effect lands 8 edges after the raw level is driven.
  task automatic press(bit m, bit i, bit d);
    btn_mode = m;
    btn_inc  = i;
    btn_dec  = d;
    step(10);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    step(10);
  endtask

  always @(negedge clk) begin
    if (load === 1'b1) begin
      ld_t e;
      loads_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_load: got %0d:%0d",
                 load_hours, load_minutes);
      end else begin
        e = exp_q.pop_front();
        chk("load_hours", load_hours, e.h);
        chk("load_minutes", load_minutes, e.m);
        chk("run_en_at_load", run_en, 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] pat;
    reset = 1'b1;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    cur_hours = 5'd12;
    cur_minutes = 6'd34;
    step(3);
    chk("rst_run_en", run_en, 1);
    chk("rst_load", load, 0);
    chk("rst_mask", blink_mask, 0);
    chk("rst_ld_h", load_hours, 0);
    reset = 1'b0;
    step(2);
    chk("t1_disp_h", disp_hours, 12);
    chk("t1_disp_m", disp_minutes, 34);
    chk("t1_run_en", run_en, 1);

    // 12:34 -> 15:32
    press(1, 0, 0);
    chk("t2_run_en_sethr", run_en, 0);
    chk("t2_capt_h", disp_hours, 12);
    chk("t2_capt_m", disp_minutes, 34);
    repeat (3) press(0, 1, 0);
    chk("t2_inc_h", disp_hours, 15);
    press(1, 0, 0);
    chk("t2_run_en_setmin", run_en, 0);
    repeat (2) press(0, 0, 1);
    chk("t2_dec_m", disp_minutes, 32);
    chk("t2_run_en_pre", run_en, 0);
    exp_q.push_back('{h: 5'd15, m: 6'd32});
    press(1, 0, 0);
    chk("t2_run_en_post", run_en, 1);
    chk("t2_hold_h", load_hours, 15);
    chk("t2_hold_m", load_minutes, 32);
    chk("t2_disp_cur", disp_hours, 12);

    // wraps: 23:00 -> 00:59
    cur_hours = 5'd23;
    cur_minutes = 6'd0;
    step(1);
    press(1, 0, 0);
    press(0, 1, 0);
    chk("t3_wrap_h", disp_hours, 0);
    press(1, 0, 0);
    press(0, 0, 1);
    chk("t3_wrap_m", disp_minutes, 59);
    exp_q.push_back('{h: 5'd0, m: 6'd59});
    press(1, 0, 0);

    // glitch and bounce on inc
    cur_hours = 5'd5;
    cur_minutes = 6'd10;
    step(1);
    press(1, 0, 0);
    btn_inc = 1'b1;
    step(3);
    btn_inc = 1'b0;
    step(10);
    chk("t4_glitch", disp_hours, 5);
    pat = 10'b1100101101;
    for (int i = 0; i < 10; i++) begin
      btn_inc = pat[i];
      step(1);
    end
    step(5);
    chk("t4_bounce_early", disp_hours, 5);
    step(1);
    chk("t4_bounce_on_time", disp_hours, 6);
    step(4);
    btn_inc = 1'b0;
    step(10);
    chk("t4_release", disp_hours, 6);
    press(1, 0, 0);
    exp_q.push_back('{h: 5'd6, m: 6'd10});
    press(1, 0, 0);

    // blink in SET_MIN
    cur_hours = 5'd9;
    cur_minutes = 6'd58;
    step(1);
    press(1, 0, 0);
    btn_mode = 1'b1;
    step(8);
    btn_mode = 1'b0;
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("t5_blink%0d", i), blink_mask,
          ((i / 8) % 2 == 1) ? 3 : 0);
      step(1);
    end
    step(4);
    btn_inc = 1'b1;
    step(8);
    btn_inc = 1'b0;
    chk("t5_inc_m", disp_minutes, 59);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t5_restart%0d", i), blink_mask,
          (i < 8) ? 0 : 3);
      step(1);
    end
    step(10);
    press(0, 1, 1);
    chk("t5_incdec", disp_minutes, 59);
    exp_q.push_back('{h: 5'd9, m: 6'd59});
    press(1, 0, 0);

    // timeout in SET_HR
    cur_hours = 5'd7;
    cur_minutes = 6'd7;
    step(1);
    press(1, 0, 0);
    step(51);
    chk("t6_before_to", run_en, 0);
    step(1);
    chk("t6_after_to", run_en, 1);
    chk("t6_to_mask", blink_mask, 0);
    chk("t6_to_disp", disp_minutes, 7);
    chk("t6_to_hold", load_hours, 9);

    // reset mid SET_MIN
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 1, 0);
    chk("t6_in_set", run_en, 0);
    reset = 1'b1;
    step(1);
    chk("t6_rst_run_en", run_en, 1);
    chk("t6_rst_load", load, 0);
    chk("t6_rst_ld_h", load_hours, 0);
    chk("t6_rst_disp", disp_hours, 7);
    reset = 1'b0;
    step(3);
    chk("t6_run_after", run_en, 1);
    chk("sb_empty", exp_q.size(), 0);
    chk("load_count", loads_seen, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
